// File: rtl/mem_manager_pkg.sv
// Types and default widths shared by the memory-manager blocks
// (the Avalon read master and the mining user logic).
package mem_manager_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        RM_IDLE,
        RM_ACTIVE
    } rm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on rdata whenever
// empty is low, and a pop advances to the next word on the following cycle.
module sync_fifo #(
    parameter int DATAWIDTH      = 32,
    parameter int FIFODEPTH_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATAWIDTH-1:0]      wdata,
    input  logic                      pop,
    output logic [DATAWIDTH-1:0]      rdata,
    output logic                      empty,
    output logic                      full,
    output logic [FIFODEPTH_LOG2:0]   used
);

    localparam int DEPTH = 1 << FIFODEPTH_LOG2;

    logic [DATAWIDTH-1:0]    mem [DEPTH];
    logic [FIFODEPTH_LOG2:0] wr_ptr;
    logic [FIFODEPTH_LOG2:0] rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only the pointers do. Stale
    // contents are never observable because rdata is forced to zero when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFODEPTH_LOG2-1:0]] <= wdata;
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign used  = wr_ptr - rd_ptr;
    assign empty = (used == '0);
    assign full  = used[FIFODEPTH_LOG2];
    assign rdata = empty ? '0 : mem[rd_ptr[FIFODEPTH_LOG2-1:0]];

endmodule

// File: rtl/avalon_read_master.sv
// Avalon-MM pipelined read master: walks a (base, length) window one word at a
// time and buffers the returned data in a show-ahead FIFO for the user logic.
module avalon_read_master
    import mem_manager_pkg::*;
#(
    parameter int ADDRESSWIDTH    = ADDR_W,
    parameter int DATAWIDTH       = DATA_W,
    parameter int BYTEENABLEWIDTH = BE_W,
    parameter int FIFODEPTH       = 8,
    parameter int FIFODEPTH_LOG2  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_output_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int PW = FIFODEPTH_LOG2 + 1;
    localparam logic [ADDRESSWIDTH-1:0] STEP     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
    localparam logic [PW:0]             DEPTH    = (PW + 1)'(FIFODEPTH);

    rm_state_t               state_q, state_n;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_n;
    logic [ADDRESSWIDTH-1:0] len_q, len_n;
    logic                    fixed_q, fixed_n;
    logic [PW-1:0]           pending_q, pending_n;
    logic [PW-1:0]           fifo_used, used_n;
    logic [PW:0]             occupancy_n;
    logic                    read_q, read_n;
    logic                    done_q;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;

    assign accept = read_q && !master_waitrequest;
    // Returns with nothing outstanding belong to a transfer abandoned by reset.
    assign push   = master_readdatavalid && (pending_q != '0) && !fifo_full;
    assign pop    = user_read_buffer && !fifo_empty;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        len_n     = len_q;
        fixed_n   = fixed_q;
        pending_n = pending_q + PW'(accept) - PW'(push);
        unique case (state_q)
            RM_IDLE: begin
                if (control_go) begin
                    addr_n  = control_read_base;
                    len_n   = control_read_length & LEN_MASK;
                    fixed_n = control_fixed_location;
                    if (len_n != '0) state_n = RM_ACTIVE;
                end
            end
            RM_ACTIVE: begin
                if (accept) begin
                    len_n = len_q - STEP;
                    if (!fixed_q) addr_n = addr_q + STEP;
                end
                if (len_n == '0 && pending_n == '0) state_n = RM_IDLE;
            end
        endcase
    end

    // master_read is registered, so the issue condition is evaluated on the
    // next-cycle counters. Without an accept the sum never grows, which keeps
    // the request stable across waitrequest.
    always_comb begin
        used_n      = fifo_used + PW'(push) - PW'(pop);
        occupancy_n = {1'b0, used_n} + {1'b0, pending_n};
        read_n      = (state_n == RM_ACTIVE) && (len_n != '0) && (occupancy_n < DEPTH);
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RM_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            fixed_q   <= 1'b0;
            pending_q <= '0;
            read_q    <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            fixed_q   <= fixed_n;
            pending_q <= pending_n;
            read_q    <= read_n;
            done_q    <= (state_n == RM_IDLE);
        end
    end

    sync_fifo #(
        .DATAWIDTH      (DATAWIDTH),
        .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (master_readdata),
        .pop   (pop),
        .rdata (user_buffer_output_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .used  (fifo_used)
    );

    assign control_done        = done_q;
    assign master_read         = read_q;
    assign master_address      = addr_q;
    assign master_byteenable   = '1;
    assign user_data_available = !fifo_empty;

endmodule

// File: tb/tb_avalon_read_master.sv
// Randomised bench for avalon_read_master: a slave model with configurable
// latency/waitrequest and a scoreboard of expected addresses and data words.
module tb_avalon_read_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control_fixed_location = 1'b0;
    logic [27:0] control_read_base = '0;
    logic [27:0] control_read_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        user_read_buffer;
    logic [31:0] user_buffer_output_data;
    logic        user_data_available;
    logic [27:0] master_address;
    logic        master_read;
    logic [3:0]  master_byteenable;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;

    avalon_read_master dut (
        .clk                     (clk),
        .reset                   (reset),
        .control_fixed_location  (control_fixed_location),
        .control_read_base       (control_read_base),
        .control_read_length     (control_read_length),
        .control_go              (control_go),
        .control_done            (control_done),
        .user_read_buffer        (user_read_buffer),
        .user_buffer_output_data (user_buffer_output_data),
        .user_data_available     (user_data_available),
        .master_address          (master_address),
        .master_read             (master_read),
        .master_byteenable       (master_byteenable),
        .master_readdata         (master_readdata),
        .master_readdatavalid    (master_readdatavalid),
        .master_waitrequest      (master_waitrequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [27:0] addr;
        int          due;
    } ret_t;

    logic [27:0] exp_addr [$];
    logic [31:0] exp_data [$];
    ret_t        pipe [$];

    int lat = 1;
    int wait_mode = 0;      // 0 none, 1 random, 2 stall the 2nd read for 5 cycles
    int pop_mode = 0;       // 0 never, 1 random, 2 every cycle
    int accepts = 0;
    int pops = 0;
    int xfer_accepts = 0;
    int stall_cnt = 0;
    int returns = 0;
    int last_valid_cyc = -10;
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] data_of(input logic [27:0] a);
        return {16'hAAAA, a[17:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    // Slave model and request-side monitor.
    initial begin : slave
        ret_t        r;
        logic        wr;
        logic        prev_stall;
        logic [27:0] prev_addr;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        master_waitrequest   = 1'b0;
        prev_stall           = 1'b0;
        prev_addr            = '0;
        forever begin
            @(negedge clk);
            #1;
            master_readdatavalid = 1'b0;
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                r = pipe.pop_front();
                master_readdatavalid = 1'b1;
                master_readdata      = data_of(r.addr);
                last_valid_cyc       = cyc;
                returns++;
            end
            if (prev_stall && !reset) begin
                check("stall_read_held", 32'(master_read), 32'd1);
                check("stall_addr_held", 32'(master_address), 32'(prev_addr));
            end
            wr = 1'b0;
            case (wait_mode)
                1: wr = ($urandom_range(0, 2) == 0);
                2: begin
                    wr = master_read && xfer_accepts == 1 && stall_cnt < 5;
                    if (wr) stall_cnt++;
                end
                default: wr = 1'b0;
            endcase
            master_waitrequest = wr;
            prev_stall = master_read && wr && !reset;
            prev_addr  = master_address;
            if (master_read && !wr && !reset) begin
                if (exp_addr.size() == 0) fail("unexpected_read");
                else check("read_addr", 32'(master_address), 32'(exp_addr.pop_front()));
                pipe.push_back('{addr: master_address, due: cyc + lat});
                accepts++;
                xfer_accepts++;
                check("occupancy_le_depth", 32'((accepts - pops) <= 8), 32'd1);
            end
            check("no_read_when_done", 32'(master_read && control_done), 32'd0);
        end
    end

    // User-side drain and data scoreboard.
    initial begin : popper
        logic p;
        user_read_buffer = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (pop_mode)
                1:       p = ($urandom_range(0, 1) == 1);
                2:       p = 1'b1;
                default: p = 1'b0;
            endcase
            if (reset) p = 1'b0;
            user_read_buffer = p;
            if (p && user_data_available) begin
                if (exp_data.size() == 0) fail("unexpected_word");
                else check("pop_data", user_buffer_output_data, exp_data.pop_front());
                pops++;
            end
        end
    end

    task automatic go(input logic [27:0] base, input logic [27:0] len, input logic fixed);
        @(negedge clk);
        control_read_base      = base;
        control_read_length    = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        @(negedge clk);
        control_go = 1'b0;
    endtask

    // Reference model: a transfer is len/4 words at base + 4*i (or base if fixed).
    task automatic start_xfer(input logic [27:0] base, input logic [27:0] len,
                              input logic fixed, output int words);
        logic [27:0] a;
        words = int'(len >> 2);
        for (int i = 0; i < words; i++) begin
            a = fixed ? base : 28'(base + 28'(4 * i));
            exp_addr.push_back(a);
            exp_data.push_back(data_of(a));
        end
        xfer_accepts = 0;
        stall_cnt    = 0;
        go(base, len, fixed);
        check("done_after_go", 32'(control_done), 32'(words == 0));
    endtask

    task automatic wait_done(input int words);
        int n = 0;
        while (control_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (control_done !== 1'b1) fail("done_timeout");
        else if (words > 0) check("done_after_last_valid", 32'(cyc), 32'(last_valid_cyc + 1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_data.size() != 0 || user_data_available) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_data.size() != 0) fail("drain_timeout");
        check("all_addrs_issued", 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int words;
        int low;
        int n;
        logic [27:0] base;
        logic [27:0] len;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_done", 32'(control_done), 32'd1);
        check("rst_read", 32'(master_read), 32'd0);
        check("rst_addr", 32'(master_address), 32'd0);
        check("rst_be", 32'(master_byteenable), 32'hF);
        check("rst_avail", 32'(user_data_available), 32'd0);
        check("rst_data", user_buffer_output_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single fixed-location word, zero-wait slave.
        lat = 1; wait_mode = 0; pop_mode = 0;
        start_xfer(28'h8000000, 28'd4, 1'b1, words);
        low = 1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (master_readdatavalid) begin
                check("t1_avail_after_valid", 32'(user_data_available), 32'd1);
                check("t1_head_data", user_buffer_output_data, 32'hAAAA0000);
            end
            if (control_done) break;
            low++;
        end
        check("t1_done_low_span", 32'(low), 32'd2);
        check("t1_done_after_last_valid", 32'(cyc), 32'(last_valid_cyc + 1));
        pop_mode = 2;
        @(negedge clk);
        @(negedge clk);
        pop_mode = 0;
        check("t1_empty_after_pop", 32'(user_data_available), 32'd0);
        check("t1_queue_empty", 32'(exp_data.size()), 32'd0);

        // 24 incrementing words, 3-cycle latency, no pops until stalled.
        lat = 3;
        start_xfer(28'h8000004, 28'd96, 1'b0, words);
        repeat (30) @(negedge clk);
        check("t2_stall_at_depth", 32'(xfer_accepts), 32'd8);
        check("t2_read_low_when_full", 32'(master_read), 32'd0);
        check("t2_done_low", 32'(control_done), 32'd0);
        pop_mode = 2;
        wait_done(words);
        wait_drain();
        check("t2_total_reads", 32'(xfer_accepts), 32'd24);
        pop_mode = 0;

        // Waitrequest held on the second read.
        lat = 2; wait_mode = 2; pop_mode = 1;
        start_xfer(28'h8000100, 28'd32, 1'b0, words);
        wait_done(words);
        wait_drain();
        check("t3_stall_cycles", 32'(stall_cnt), 32'd5);
        check("t3_total_reads", 32'(xfer_accepts), 32'd8);
        wait_mode = 0;

        // Zero length, then a length that rounds down to one word.
        start_xfer(28'h8000200, 28'd0, 1'b0, words);
        check("t4_no_read_len0", 32'(master_read), 32'd0);
        repeat (5) @(negedge clk);
        check("t4_done_len0", 32'(control_done), 32'd1);
        check("t4_reads_len0", 32'(xfer_accepts), 32'd0);
        start_xfer(28'h8000300, 28'd6, 1'b0, words);
        wait_done(words);
        wait_drain();
        check("t4_reads_len6", 32'(xfer_accepts), 32'd1);

        // Reset with three reads outstanding; late returns must be dropped.
        lat = 12; pop_mode = 0;
        start_xfer(28'h8000400, 28'd12, 1'b0, words);
        n = 0;
        while (xfer_accepts < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (xfer_accepts < 3) fail("t5_accept_timeout");
        reset = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        accepts = 0;
        pops = 0;
        returns = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (pipe.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("t5_late_returns_seen", 32'(returns), 32'd3);
        check("t5_avail", 32'(user_data_available), 32'd0);
        check("t5_done", 32'(control_done), 32'd1);
        check("t5_read", 32'(master_read), 32'd0);
        check("t5_data", user_buffer_output_data, 32'd0);

        // Go while active is ignored.
        lat = 2; pop_mode = 1;
        start_xfer(28'h8000500, 28'd16, 1'b0, words);
        n = 0;
        while (xfer_accepts < 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        go(28'h8000900, 28'd64, 1'b1);
        wait_done(words);
        wait_drain();
        check("t6_reads_unchanged", 32'(xfer_accepts), 32'd4);

        // Random transfers, including an address wrap; FIFO carries over between them.
        wait_mode = 1;
        for (int t = 0; t < 14; t++) begin
            base = (t == 0) ? 28'hFFFFFF8 : 28'($urandom);
            len  = (t == 0) ? 28'd16 : 28'($urandom_range(0, 64));
            lat  = $urandom_range(1, 4);
            start_xfer(base, len, 1'($urandom_range(0, 1)), words);
            wait_done(words);
            check("rand_reads", 32'(xfer_accepts), 32'(words));
        end
        pop_mode = 2;
        wait_drain();
        pop_mode = 0;
        wait_mode = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
